state_loader: RTL and testbench

STATE_LOADER -- requirements
Module: state_loader

---
 rtl/state_loader_pkg.sv | 14 +
 rtl/state_buffer.sv | 29 ++
 rtl/state_loader.sv | 110 +++++++++++
 tb/tb_state_loader.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/state_loader_pkg.sv
// Shared constants and FSM state type for the state loader.
package state_loader_pkg;
  localparam int LINE_W  = 25;
  localparam int LINES   = 64;
  localparam int STATE_W = LINE_W * LINES;
  localparam int LIDX_W  = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FETCH = 2'd2,
    HOLD  = 2'd3
  } state_e;
endpackage

// File: rtl/state_buffer.sv
// Line buffer: LINES x LINE_W registers, one write port, whole contents exposed flat.
module state_buffer
  import state_loader_pkg::*;
#(
  parameter int LINE_W = state_loader_pkg::LINE_W,
  parameter int LINES  = state_loader_pkg::LINES,
  parameter int AW     = state_loader_pkg::LIDX_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_we,
  input  logic [AW-1:0]           i_waddr,
  input  logic [LINE_W-1:0]       i_wdata,
  output logic [LINE_W*LINES-1:0] o_rdata
);

  logic [LINE_W*LINES-1:0] r_mem;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mem <= '0;
    end else if (i_we) begin
      r_mem[int'(i_waddr) * LINE_W +: LINE_W] <= i_wdata;
    end
  end

  assign o_rdata = r_mem;

endmodule

// File: rtl/state_loader.sv
// Loads one file of LINES lines from an upstream reader and offers it as a flat state word.
// Optional STATE_LOADER_CHECKSUM_EN adds an XOR checksum output over the captured lines.
module state_loader
  import state_loader_pkg::*;
#(
  parameter int LINE_W = state_loader_pkg::LINE_W,
  parameter int LINES  = state_loader_pkg::LINES,
  parameter int FIDX_W = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [FIDX_W-1:0]       file_idx,
  output logic                    read_file,
  output logic [FIDX_W-1:0]       file_index,
  output logic [LIDX_W-1:0]       line_index,
  input  logic [LINE_W-1:0]       line_in,
  output logic                    busy,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LINE_W*LINES-1:0] state_out
`ifdef STATE_LOADER_CHECKSUM_EN
  ,
  output logic [LINE_W-1:0]       checksum
`endif
);

  localparam logic [LIDX_W-1:0] LAST_LINE = LIDX_W'(LINES - 1);

  state_e              r_state;
  state_e              w_next;
  logic [FIDX_W-1:0]   r_file_idx;
  logic [LIDX_W-1:0]   r_line_idx;
  logic                w_accept;
  logic                w_capture;
  logic                w_last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_capture = 1'b0;
    w_last    = (r_line_idx == LAST_LINE);
    case (r_state)
      IDLE: begin
        if (start) begin
          w_accept = 1'b1;
          w_next   = LOAD;
        end
      end
      LOAD:  w_next = FETCH;
      FETCH: begin
        w_capture = 1'b1;
        if (w_last) w_next = HOLD;
      end
      HOLD: begin
        if (out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Line address wraps back to zero on the capture of the last line.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_file_idx <= '0;
      r_line_idx <= '0;
    end else begin
      if (w_accept) r_file_idx <= file_idx;
      if (r_state == LOAD)  r_line_idx <= '0;
      else if (w_capture)   r_line_idx <= w_last ? '0 : r_line_idx + 1'b1;
    end
  end

  state_buffer #(
    .LINE_W (LINE_W),
    .LINES  (LINES),
    .AW     (LIDX_W)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_capture),
    .i_waddr (r_line_idx),
    .i_wdata (line_in),
    .o_rdata (state_out)
  );

`ifdef STATE_LOADER_CHECKSUM_EN
  logic [LINE_W-1:0] r_csum;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           r_csum <= '0;
    else if (w_accept)  r_csum <= '0;
    else if (w_capture) r_csum <= r_csum ^ line_in;
  end

  assign checksum = r_csum;
`endif

  assign read_file  = (r_state == LOAD);
  assign busy       = (r_state != IDLE);
  assign out_valid  = (r_state == HOLD);
  assign file_index = r_file_idx;
  assign line_index = r_line_idx;

endmodule

// File: tb/tb_state_loader.sv
// Bench for state_loader: vector table for the first cycles, randomized loads vs. a reference model.
module tb_state_loader;
  localparam int LW = 25;
  localparam int NL = 64;
  localparam int FW = 10;
  localparam int SW = LW * NL;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [FW-1:0] file_idx;
  logic          read_file;
  logic [FW-1:0] file_index;
  logic [5:0]    line_index;
  logic [LW-1:0] line_in;
  logic          busy;
  logic          out_valid;
  logic          out_ready;
  logic [SW-1:0] state_out;
`ifdef STATE_LOADER_CHECKSUM_EN
  logic [LW-1:0] checksum;
`endif

  logic [LW-1:0] rd_data [NL];
  int n_checks = 0;
  int n_errs   = 0;

  assign line_in = rd_data[line_index];

  always #5 clk = ~clk;

  state_loader #(.LINE_W(LW), .LINES(NL), .FIDX_W(FW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .file_idx   (file_idx),
    .read_file  (read_file),
    .file_index (file_index),
    .line_index (line_index),
    .line_in    (line_in),
    .busy       (busy),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .state_out  (state_out)
`ifdef STATE_LOADER_CHECKSUM_EN
    ,
    .checksum   (checksum)
`endif
  );

  typedef struct {
    logic          start;
    logic [FW-1:0] fidx;
    logic          exp_rf;
    logic          exp_busy;
    logic          exp_ov;
    logic [FW-1:0] exp_fi;
    logic [5:0]    exp_li;
  } vec_t;

  // The expected state is simply every reader line laid out at k*LW.
  function automatic logic [SW-1:0] model_state();
    logic [SW-1:0] s;
    for (int k = 0; k < NL; k++) s[k*LW +: LW] = rd_data[k];
    return s;
  endfunction

  function automatic logic [LW-1:0] model_csum();
    logic [LW-1:0] x;
    x = '0;
    for (int k = 0; k < NL; k++) x = x ^ rd_data[k];
    return x;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_state(input string nm, input logic [SW-1:0] exp);
    n_checks++;
    if (state_out !== exp) begin
      n_errs++;
      for (int k = 0; k < NL; k++) begin
        if (state_out[k*LW +: LW] !== exp[k*LW +: LW]) begin
          $display("FAIL %s: line %0d got %0h expected %0h", nm, k,
                   state_out[k*LW +: LW], exp[k*LW +: LW]);
          break;
        end
      end
    end
  endtask

  task automatic fill_random();
    for (int k = 0; k < NL; k++) rd_data[k] = LW'($urandom);
  endtask

  // Count edges until out_valid rises; n0 edges since the start edge already elapsed.
  task automatic wait_valid(input int n0, input logic [FW-1:0] fidx, input string tag);
    int n;
    int rf;
    n  = n0;
    rf = 0;
    while (!out_valid && n < 200) begin
      start = ($urandom_range(0, 3) == 0);
      file_idx = ~fidx;
      tick();
      n++;
      if (read_file) rf++;
    end
    start = 1'b0;
    chk({tag, " latency"}, 64'(n), 64'd65);
    chk({tag, " read_file repulse"}, 64'(rf), 64'd0);
    chk({tag, " file_index held"}, 64'(file_index), 64'(fidx));
  endtask

  task automatic hold_and_release(input logic [SW-1:0] exp_s, input logic [LW-1:0] exp_c,
                                  input int hold, input bit start_on_hs, input string tag);
    out_ready = 1'b0;
    chk({tag, " hold valid"}, 64'(out_valid), 64'd1);
    chk_state({tag, " state"}, exp_s);
`ifdef STATE_LOADER_CHECKSUM_EN
    chk({tag, " checksum"}, 64'(checksum), 64'(exp_c));
`else
    if (exp_c !== exp_c) $display("unreachable");
`endif
    for (int i = 0; i < hold; i++) begin
      tick();
      chk({tag, " stall valid"}, 64'(out_valid), 64'd1);
      chk_state({tag, " stall state"}, exp_s);
    end
    out_ready = 1'b1;
    start     = start_on_hs;
    file_idx  = 10'd9;
    tick();
    out_ready = 1'b0;
    start     = 1'b0;
    chk({tag, " released valid"}, 64'(out_valid), 64'd0);
    chk({tag, " released busy"}, 64'(busy), 64'd0);
    chk_state({tag, " retained"}, exp_s);
    if (start_on_hs) begin
      tick();
      chk({tag, " hs start ignored busy"}, 64'(busy), 64'd0);
      chk({tag, " hs start ignored rf"}, 64'(read_file), 64'd0);
    end
  endtask

  task automatic run_load(input logic [FW-1:0] fidx, input int hold, input bit start_on_hs,
                          input string tag);
    logic [SW-1:0] exp_s;
    logic [LW-1:0] exp_c;
    exp_s = model_state();
    exp_c = model_csum();
    start    = 1'b1;
    file_idx = fidx;
    tick();
    start = 1'b0;
    chk({tag, " read_file"}, 64'(read_file), 64'd1);
    chk({tag, " file_index"}, 64'(file_index), 64'(fidx));
    wait_valid(0, fidx, tag);
    hold_and_release(exp_s, exp_c, hold, start_on_hs, tag);
  endtask

  initial begin
    vec_t vecs[5];
    logic [SW-1:0] exp0;
    int n;
    int ov_seen;

    vecs[0] = '{1'b1, 10'd3, 1'b1, 1'b1, 1'b0, 10'd3, 6'd0};
    vecs[1] = '{1'b0, 10'd0, 1'b0, 1'b1, 1'b0, 10'd3, 6'd0};
    vecs[2] = '{1'b1, 10'd7, 1'b0, 1'b1, 1'b0, 10'd3, 6'd1};
    vecs[3] = '{1'b0, 10'd0, 1'b0, 1'b1, 1'b0, 10'd3, 6'd2};
    vecs[4] = '{1'b1, 10'd7, 1'b0, 1'b1, 1'b0, 10'd3, 6'd3};

    rst       = 1'b0;
    start     = 1'b0;
    out_ready = 1'b0;
    file_idx  = '0;
    for (int k = 0; k < NL; k++) rd_data[k] = LW'(k);
    repeat (3) tick();
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset read_file", 64'(read_file), 64'd0);
    chk("reset line_index", 64'(line_index), 64'd0);
    chk("reset file_index", 64'(file_index), 64'd0);
    chk_state("reset state", '0);
    rst = 1'b1;
    tick();
    chk("idle after reset busy", 64'(busy), 64'd0);

    exp0 = model_state();
    for (int i = 0; i < 5; i++) begin
      start    = vecs[i].start;
      file_idx = vecs[i].fidx;
      tick();
      chk($sformatf("vec%0d read_file", i), 64'(read_file), 64'(vecs[i].exp_rf));
      chk($sformatf("vec%0d busy", i), 64'(busy), 64'(vecs[i].exp_busy));
      chk($sformatf("vec%0d out_valid", i), 64'(out_valid), 64'(vecs[i].exp_ov));
      chk($sformatf("vec%0d file_index", i), 64'(file_index), 64'(vecs[i].exp_fi));
      chk($sformatf("vec%0d line_index", i), 64'(line_index), 64'(vecs[i].exp_li));
    end
    start = 1'b0;
    wait_valid(4, 10'd3, "first");
    chk("first line_index wrap", 64'(line_index), 64'd0);
    hold_and_release(exp0, model_csum(), 10, 1'b0, "first");

    run_load(10'd4, 2, 1'b0, "b2b");

    for (int t = 0; t < 4; t++) begin
      fill_random();
      run_load(FW'($urandom), $urandom_range(0, 5), (t == 3), $sformatf("rand%0d", t));
    end

    fill_random();
    start    = 1'b1;
    file_idx = 10'd5;
    tick();
    start = 1'b0;
    n = 0;
    while (line_index != 6'd20 && n < 100) begin
      tick();
      n++;
    end
    chk("pre-reset line_index", 64'(line_index), 64'd20);
    #2 rst = 1'b0;
    #1;
    chk("async reset busy", 64'(busy), 64'd0);
    chk("async reset out_valid", 64'(out_valid), 64'd0);
    chk("async reset read_file", 64'(read_file), 64'd0);
    chk("async reset line_index", 64'(line_index), 64'd0);
    chk("async reset file_index", 64'(file_index), 64'd0);
    chk_state("async reset state", '0);
`ifdef STATE_LOADER_CHECKSUM_EN
    chk("async reset checksum", 64'(checksum), 64'd0);
`endif
    tick();
    tick();
    rst = 1'b1;
    ov_seen = 0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (out_valid || busy) ov_seen++;
    end
    chk("abandoned load quiet", 64'(ov_seen), 64'd0);

    fill_random();
    run_load(10'd11, 3, 1'b0, "post-reset");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
